// File: rtl/serial_deser.sv
// serial_deser: receive stage for the MSB-first serial frame of the
// capture-triggered serializer. The shared capture strobe sets framing
// because the line has no start bit. The frame is WORD_W*NUM_WORDS bits.
// The words are presented in parallel together with a one-cycle data_valid.
// Optional feature macro: SERIAL_DESER_FRAME_CNT_EN adds an 8-bit wrapping
// frame_cnt output that counts data_valid pulses.
module serial_deser #(
    parameter int WORD_W           = 16,
    parameter int NUM_WORDS        = 3,
    parameter int FIRST_SAMPLE_DLY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              serial_in,
    input  logic              err_clr,
    output logic [WORD_W-1:0] data_out1,
    output logic [WORD_W-1:0] data_out2,
    output logic [WORD_W-1:0] data_out3,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun
`ifdef SERIAL_DESER_FRAME_CNT_EN
    ,
    output logic [7:0]        frame_cnt
`endif
);

    localparam int FRAME_BITS = WORD_W * NUM_WORDS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DLY_W      = (FIRST_SAMPLE_DLY > 1) ? $clog2(FIRST_SAMPLE_DLY) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(FIRST_SAMPLE_DLY - 1);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DLY_W-1:0]        dly_q, dly_d;
    logic [CNT_W-1:0]        bit_q, bit_d;
    // The last frame bit goes straight from serial_in into the output words,
    // so only FRAME_BITS-1 earlier bits ever need to be held.
    logic [FRAME_BITS-2:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   frame;
    logic [WORD_W-1:0]       out1_q, out1_d;
    logic [WORD_W-1:0]       out2_q, out2_d;
    logic [WORD_W-1:0]       out3_q, out3_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;

    // Next-state, datapath and flag logic for the IDLE/DELAY/SHIFT framing FSM
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        out1_d    = out1_q;
        out2_d    = out2_q;
        out3_d    = out3_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        frame     = {shift_q, serial_in};

        // A set event later in this block overrides the clear.
        if (err_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (capture) begin
                    if (FIRST_SAMPLE_DLY == 1) begin
                        state_d = SHIFT;
                        bit_d   = '0;
                    end else begin
                        state_d = DELAY;
                        dly_d   = DLY_LOAD;
                    end
                end
            end
            DELAY: begin
                if (capture) begin
                    overrun_d = 1'b1;
                end
                if (dly_q == DLY_ONE) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                end else begin
                    dly_d = dly_q - DLY_ONE;
                end
            end
            SHIFT: begin
                // A capture on the final edge still counts as busy.
                if (capture) begin
                    overrun_d = 1'b1;
                end
                shift_d = frame[FRAME_BITS-2:0];
                if (bit_q == LAST_BIT) begin
                    out1_d  = frame[FRAME_BITS-1 -: WORD_W];
                    out2_d  = frame[FRAME_BITS-1-WORD_W -: WORD_W];
                    out3_d  = frame[FRAME_BITS-1-2*WORD_W -: WORD_W];
                    valid_d = 1'b1;
                    bit_d   = '0;
                    state_d = IDLE;
                end else begin
                    bit_d = bit_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters, shift register and output registers; async reset aborts any frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dly_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            out1_q    <= '0;
            out2_q    <= '0;
            out3_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
            out3_q    <= out3_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out1  = out1_q;
    assign data_out2  = out2_q;
    assign data_out3  = out3_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

`ifdef SERIAL_DESER_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Count completed frames on the same edge the output words load; wraps at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (valid_d) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Testbench for serial_deser. Stimulus pushes expected frames into a queue,
// and a separate monitor pops and compares them on every data_valid pulse.
// Build with SERIAL_DESER_FRAME_CNT_EN defined to run the frame counter test too.
module tb_serial_deser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture = 1'b0;
    logic        serial_in = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] data_out1, data_out2, data_out3;
    logic        data_valid, busy, overrun;
`ifdef SERIAL_DESER_FRAME_CNT_EN
    logic [7:0]  frame_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_pushed = 0;

    typedef struct packed {
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] w3;
    } frame_t;

    frame_t exp_q[$];

    serial_deser #(
        .WORD_W(16),
        .NUM_WORDS(3),
        .FIRST_SAMPLE_DLY(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .capture(capture),
        .serial_in(serial_in),
        .err_clr(err_clr),
        .data_out1(data_out1),
        .data_out2(data_out2),
        .data_out3(data_out3),
        .data_valid(data_valid),
        .busy(busy),
        .overrun(overrun)
`ifdef SERIAL_DESER_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every data_valid pulse must match the oldest expected frame.
    initial begin
        logic prev_valid;
        frame_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && data_valid) begin
                n_valid++;
                check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out1", {16'd0, data_out1}, {16'd0, e.w1});
                    check("data_out2", {16'd0, data_out2}, {16'd0, e.w2});
                    check("data_out3", {16'd0, data_out3}, {16'd0, e.w3});
                end
            end
            prev_valid = data_valid;
        end
    end

    // Drive one frame: capture at e0, bits on e2..e49. extra_cap re-asserts capture
    // at that edge index; abort_at drops rst_n just before that edge and returns.
    task automatic run_frame(input logic [15:0] w1, input logic [15:0] w2,
                             input logic [15:0] w3, input int extra_cap,
                             input int abort_at);
        logic [47:0] bits;
        frame_t f;
        bits = {w1, w2, w3};
        if (abort_at < 0) begin
            f.w1 = w1;
            f.w2 = w2;
            f.w3 = w3;
            exp_q.push_back(f);
            n_pushed++;
        end
        capture   = 1'b1;
        serial_in = 1'b0;
        tick();                                   // e0
        check("busy_after_e0", {31'd0, busy}, 32'd1);
        capture = 1'b0;
        tick();                                   // e1, serial_in ignored
        for (int i = 0; i < 48; i++) begin
            if (i + 2 == abort_at) begin
                rst_n   = 1'b0;
                capture = 1'b0;
                return;
            end
            capture   = (i + 2 == extra_cap);
            serial_in = bits[47-i];
            tick();                               // e(i+2)
        end
        capture = 1'b0;
        check("busy_after_e49", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic idle_bad;

        // Reset then idle with a toggling line and no capture.
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {data_out1, data_out2}, 32'd0);
        check("reset_flags", {data_out3, 13'd0, data_valid, busy, overrun}, 32'd0);
        rst_n = 1'b1;
        idle_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            serial_in = ~serial_in;
            tick();
            if ({data_out1, data_out2, data_out3, data_valid, busy, overrun} != '0)
                idle_bad = 1'b1;
        end
        check("idle_quiet", {31'd0, idle_bad}, 32'd0);
        tick();

        // Basic frame.
        run_frame(16'h1234, 16'hABCD, 16'hF00F, -1, -1);
        check("basic_overrun", {31'd0, overrun}, 32'd0);
        repeat (3) tick();

        // Overrun: capture at e20 is ignored but sets a sticky flag.
        run_frame(16'hFFFF, 16'h0000, 16'h5555, 20, -1);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        repeat (5) tick();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("overrun_cleared", {31'd0, overrun}, 32'd0);
        repeat (2) tick();

        // Reset mid-frame at e30: outputs clear immediately, no data_valid.
        run_frame(16'hDEAD, 16'hBEEF, 16'hCAFE, -1, 30);
        #1;
        check("abort_data", {data_out1, data_out2}, 32'd0);
        check("abort_flags", {data_out3, 13'd0, data_valid, busy, overrun}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_frame(16'h0001, 16'h8000, 16'h7FFE, -1, -1);

        // Back-to-back: next capture at e50 is accepted.
        run_frame(16'hA5A5, 16'h3C3C, 16'h0F0F, -1, -1);
        check("b2b_no_overrun", {31'd0, overrun}, 32'd0);

        // Capture on the completing edge e49 is ignored and flags overrun.
        run_frame(16'h1357, 16'h2468, 16'h9BDF, 49, -1);
        check("e49_overrun", {31'd0, overrun}, 32'd1);
        repeat (4) tick();
        check("e49_not_started", {31'd0, busy}, 32'd0);

`ifdef SERIAL_DESER_FRAME_CNT_EN
        // 257 consecutive frames from a fresh reset: counter wraps to 1.
        rst_n = 1'b0;
        tick();
        check("cnt_reset", {24'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();
        for (int n = 0; n < 257; n++) begin
            run_frame(16'(n), 16'(n * 3 + 7), ~16'(n), -1, -1);
        end
        tick();
        check("frame_cnt_wrap", {24'd0, frame_cnt}, 32'd1);
`endif

        repeat (5) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("valid_count", n_valid, n_pushed);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
